lightgun_sense: RTL and testbench
=================================

Name: lightgun_sense

Overview:
- Emulates the XG-1/light-phaser photodiode downstream of the Maria video output.
- Tracks beam position from the pixel-enable strobe and the blanking signals, then compares it against a host-supplied gun aim point.
- When the beam crosses the aim window on a bright enough pixel, it drives an active-low light-sense pulse into the TIA/RIOT input path. At most one hit is allowed per frame.
- Also conditions the trigger input for the same path.

Parameters:
- WIN_X, 4: half-width of the horizontal hit window, in pixels.
- WIN_Y, 2: number of lines below gun_y that still count as a hit.
- LUM_THRESH, 4'd8: minimum luminance (uv_in[3:0]) that registers as light.
- PULSE_LINES, 3: number of lines sense_n is held low after a hit.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- mclk0  in  1  one-clk_sys pixel enable; one pulse per Maria pixel.
- uv_in  in  8  Maria pixel, {chroma[7:4], luma[3:0]}.
- hblank  in  1  horizontal blank, high during blank.
- vblank  in  1  vertical blank, high during blank.
- gun_x  in  9  aim column, 0-based, in active pixels.
- gun_y  in  9  aim line, 0-based, in active lines.
- gun_en  in  1  gun connected; when low, outputs stay idle.
- trigger_raw  in  1  host trigger, asynchronous, active-high.
- sense_n  out  1  light sense to the TIA input, active-low.
- trigger_n  out  1  synchronized trigger, active-low.
- beam_x  out  9  current active pixel column.
- beam_y  out  9  current active line.
- hit  out  1  one-clk_sys strobe on the cycle a hit is detected.

Behaviour:
- Reset values: sense_n=1, trigger_n=1, beam_x=0, beam_y=0, hit=0, state=IDLE, line counter=0, 2-flop synchronizer=0.
- Edge detection: hblank and vblank are registered once each. A rising edge (rise) and falling edge (fall) are taken from the registered copy versus the current input.
- beam_x:
  - Clears on hblank rise.
  - Increments on mclk0 while hblank=0 && vblank=0.
  - Saturates at 511 (no wrap).
- beam_y:
  - Clears on vblank rise.
  - Increments on hblank rise while vblank=0.
  - The first active line is therefore 0.
  - Saturates at 511.
- in_win is combinational, true when all of:
  - hblank=0, vblank=0, mclk0=1;
  - beam_x + WIN_X >= gun_x and beam_x <= gun_x + WIN_X, computed at 10 bits (no underflow, no overflow);
  - beam_y >= gun_y and beam_y <= gun_y + WIN_Y, computed at 10 bits;
  - uv_in[3:0] >= LUM_THRESH.
- State machine:
  - IDLE: on in_win && gun_en, go to PULSE; hit=1 for that cycle; sense_n<=0 next cycle; line counter<=PULSE_LINES.
  - PULSE: sense_n=0. Decrement line counter on each hblank rise. When it reaches 0, sense_n<=1 and go to HOLDOFF.
  - HOLDOFF: sense_n=1. Ignore in_win. Go to IDLE on vblank rise.
- Vblank rise while in PULSE: terminate immediately, sense_n<=1, go to IDLE. A pulse never spans frames.
- gun_en=0 in any state: next cycle go to IDLE with sense_n=1. trigger_n is forced to 1.
- Trigger path:
  - trigger_raw passes through a 2-flop synchronizer.
  - trigger_n = ~sync while gun_en=1, otherwise 1.
  - Latency is 2 clk_sys cycles plus the output register.
- Simultaneous events on one cycle:
  - vblank rise has priority over hblank rise and over in_win.
  - Counter clears take priority over increments.
- gun_x or gun_y beyond the active area: no hit ever occurs. This is legal and not an error.
- Reset asserted mid-pulse: sense_n returns to 1 asynchronously.

Test Plan:
- Synthetic frame (320 px, 242 lines), gun=(100,50), pixel (100,50) luma=0xF, rest 0 -> hit strobes once at beam (100,50); sense_n low for exactly 3 hblank rises; no second hit that frame.
- Same frame, bright pixel at (104,52) -> hit; pixel at (105,50) or (100,53) -> no hit.
- Bright pixel at target with luma=7 -> no hit; luma=8 -> hit.
- gun=(2,0), bright at (0,0) -> hit; confirms no underflow of the window compare.
- Hit on line 240 with vblank rising 2 lines later -> sense_n returns high at vblank rise; next frame's hit is accepted.
- trigger_raw pulse with gun_en=1 -> trigger_n low 3 cycles later; gun_en=0 -> trigger_n stays 1 and no hits; reset mid-PULSE -> sense_n=1 immediately.

Source files
------------

// File: rtl/lightgun_sense.sv
// Light-phaser photodiode model: tracks the Maria beam position and pulses an
// active-low light-sense line when the beam crosses the gun aim window.
module lightgun_sense #(
   parameter int         WIN_X       = 4,
   parameter int         WIN_Y       = 2,
   parameter logic [3:0] LUM_THRESH  = 4'd8,
   parameter int         PULSE_LINES = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       mclk0,
   input  logic [7:0] uv_in,
   input  logic       hblank,
   input  logic       vblank,
   input  logic [8:0] gun_x,
   input  logic [8:0] gun_y,
   input  logic       gun_en,
   input  logic       trigger_raw,
   output logic       sense_n,
   output logic       trigger_n,
   output logic [8:0] beam_x,
   output logic [8:0] beam_y,
   output logic       hit
);

   localparam int CW = $clog2(PULSE_LINES + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] line_cnt, line_cnt_d;
   logic          hblank_q, vblank_q;
   logic          h_rise, v_rise;
   logic          in_win;
   logic          sync1, sync2;
   logic [9:0]    bx10, by10, gx10, gy10;
   logic          unused_chroma;

   // Only luma decides brightness; chroma is deliberately ignored.
   assign unused_chroma = ^uv_in[7:4];

   assign h_rise = hblank & ~hblank_q;
   assign v_rise = vblank & ~vblank_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hblank_q <= 1'b0;
         vblank_q <= 1'b0;
      end else begin
         hblank_q <= hblank;
         vblank_q <= vblank;
      end
   end

   // Beam position counters: clears win over increments, both saturate at 511.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         beam_x <= 9'd0;
         beam_y <= 9'd0;
      end else begin
         if (h_rise)
            beam_x <= 9'd0;
         else if (mclk0 && !hblank && !vblank && beam_x != 9'd511)
            beam_x <= beam_x + 9'd1;

         if (v_rise)
            beam_y <= 9'd0;
         else if (h_rise && !vblank && beam_y != 9'd511)
            beam_y <= beam_y + 9'd1;
      end
   end

   // Window compare widened to 10 bits so neither side can wrap.
   assign bx10 = {1'b0, beam_x};
   assign by10 = {1'b0, beam_y};
   assign gx10 = {1'b0, gun_x};
   assign gy10 = {1'b0, gun_y};

   assign in_win = !hblank && !vblank && mclk0
                && (bx10 + 10'(WIN_X) >= gx10) && (bx10 <= gx10 + 10'(WIN_X))
                && (by10 >= gy10) && (by10 <= gy10 + 10'(WIN_Y))
                && (uv_in[3:0] >= LUM_THRESH);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         line_cnt <= '0;
         sense_n  <= 1'b1;
      end else begin
         state    <= state_d;
         line_cnt <= line_cnt_d;
         sense_n  <= (state_d != PULSE);
      end
   end

   always_comb begin
      state_d    = state;
      line_cnt_d = line_cnt;
      hit        = 1'b0;
      if (!gun_en) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_win && !v_rise) begin
                  state_d    = PULSE;
                  line_cnt_d = CW'(PULSE_LINES);
                  hit        = 1'b1;
               end
            end
            PULSE: begin
               // A pulse is cut short at the frame boundary.
               if (v_rise) begin
                  state_d = IDLE;
               end else if (h_rise) begin
                  if (line_cnt <= CW'(1)) begin
                     line_cnt_d = '0;
                     state_d    = HOLDOFF;
                  end else begin
                     line_cnt_d = line_cnt - CW'(1);
                  end
               end
            end
            HOLDOFF: begin
               if (v_rise)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         trigger_n <= 1'b1;
      end else begin
         sync1     <= trigger_raw;
         sync2     <= sync1;
         trigger_n <= gun_en ? ~sync2 : 1'b1;
      end
   end

endmodule

// File: tb/tb_lightgun_sense.sv
// Directed bench for lightgun_sense: table of synthetic frames plus hand-written
// trigger, frame-boundary and reset sequences.
module tb_lightgun_sense;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       mclk0;
   logic [7:0] uv_in;
   logic       hblank, vblank;
   logic [8:0] gun_x, gun_y;
   logic       gun_en;
   logic       trigger_raw;
   logic       sense_n, trigger_n, hit;
   logic [8:0] beam_x, beam_y;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam int VB = 2;

   lightgun_sense dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .mclk0       (mclk0),
      .uv_in       (uv_in),
      .hblank      (hblank),
      .vblank      (vblank),
      .gun_x       (gun_x),
      .gun_y       (gun_y),
      .gun_en      (gun_en),
      .trigger_raw (trigger_raw),
      .sense_n     (sense_n),
      .trigger_n   (trigger_n),
      .beam_x      (beam_x),
      .beam_y      (beam_y),
      .hit         (hit)
   );

   always #5 clk_sys = ~clk_sys;

   // Event monitor, sampled mid-cycle: hit count/position and hblank rises seen while sense_n is low.
   int   hit_total  = 0;
   int   low_rises  = 0;
   int   last_hx    = 0;
   int   last_hy    = 0;
   logic hb_prev    = 1'b0;

   always @(negedge clk_sys) begin
      if (hit) begin
         hit_total = hit_total + 1;
         last_hx   = int'(beam_x);
         last_hy   = int'(beam_y);
      end
      if (hblank && !hb_prev && !sense_n)
         low_rises = low_rises + 1;
      hb_prev = hblank;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One frame: VB blank lines then active lines, each line px pixels + 4 blank clocks.
   task automatic run_frame(input int px, input int lines, input int bx, input int by,
                            input logic [3:0] luma, input int fill);
      int y;
      vblank = 1'b1;
      for (int l = 0; l < VB + lines; l++) begin
         y = l - VB;
         for (int c = 0; c < px; c++) begin
            hblank = 1'b0;
            mclk0  = 1'b1;
            uv_in  = (l >= VB && ((c == bx && y == by) || fill != 0)) ? {4'h3, luma} : 8'h30;
            tick();
         end
         hblank = 1'b1;
         mclk0  = 1'b0;
         uv_in  = 8'h00;
         repeat (4) tick();
         if (l == VB - 1)
            vblank = 1'b0;
      end
   endtask

   typedef struct {
      int gx, gy, bx, by, luma, fill, en, px, lines, hits, hx, hy;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int h0, r0;

      vecs[0]  = '{100, 50, 100, 50, 15, 0, 1, 110, 56, 1, 100, 50};
      vecs[1]  = '{100, 50, 104, 52, 15, 0, 1, 110, 56, 1, 104, 52};
      vecs[2]  = '{100, 50, 105, 50, 15, 0, 1, 110, 56, 0,   0,  0};
      vecs[3]  = '{100, 50, 100, 53, 15, 0, 1, 110, 56, 0,   0,  0};
      vecs[4]  = '{ 20, 10,  20, 10,  7, 0, 1,  32, 14, 0,   0,  0};
      vecs[5]  = '{ 20, 10,  20, 10,  8, 0, 1,  32, 14, 1,  20, 10};
      vecs[6]  = '{  2,  0,   0,  0, 15, 0, 1,  32, 14, 1,   0,  0};
      vecs[7]  = '{ 20, 10,  16, 10, 15, 0, 1,  32, 14, 1,  16, 10};
      vecs[8]  = '{ 20, 10,  20,  9, 15, 0, 1,  32, 14, 0,   0,  0};
      vecs[9]  = '{400, 10,  31, 10, 15, 1, 1,  32, 14, 0,   0,  0};
      vecs[10] = '{ 20, 10,  20, 10, 15, 0, 0,  32, 14, 0,   0,  0};

      reset = 1'b1; mclk0 = 1'b0; uv_in = 8'h00; hblank = 1'b0; vblank = 1'b0;
      gun_x = 9'd0; gun_y = 9'd0; gun_en = 1'b0; trigger_raw = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      check("reset sense_n",   int'(sense_n),   1);
      check("reset trigger_n", int'(trigger_n), 1);
      check("reset beam_x",    int'(beam_x),    0);
      check("reset beam_y",    int'(beam_y),    0);
      check("reset hit",       int'(hit),       0);
      reset = 1'b0;
      tick();

      // Table of frames; the fill vector also proves a single hit per frame.
      vecs[9].gx = 400;
      for (int i = 0; i < 11; i++) begin
         gun_x  = 9'(vecs[i].gx);
         gun_y  = 9'(vecs[i].gy);
         gun_en = vecs[i].en[0];
         h0 = hit_total;
         r0 = low_rises;
         run_frame(vecs[i].px, vecs[i].lines, vecs[i].bx, vecs[i].by,
                   4'(vecs[i].luma), vecs[i].fill);
         check($sformatf("vec%0d hits", i), hit_total - h0, vecs[i].hits);
         if (vecs[i].hits > 0) begin
            check($sformatf("vec%0d hit_x", i), last_hx, vecs[i].hx);
            check($sformatf("vec%0d hit_y", i), last_hy, vecs[i].hy);
            check($sformatf("vec%0d pulse lines", i), low_rises - r0, 3);
         end
      end

      // Full-window fill: many bright in-window pixels, still exactly one hit at the first one.
      gun_x = 9'd20; gun_y = 9'd10; gun_en = 1'b1;
      h0 = hit_total;
      run_frame(32, 14, 0, 0, 4'hF, 1);
      check("fill hits",  hit_total - h0, 1);
      check("fill hit_x", last_hx, 16);
      check("fill hit_y", last_hy, 10);

      // Hit on line 240, frame ends two lines later: vblank rise ends the pulse.
      gun_x = 9'd4; gun_y = 9'd240;
      h0 = hit_total;
      r0 = low_rises;
      run_frame(8, 242, 4, 240, 4'hF, 0);
      check("l240 hits",        hit_total - h0, 1);
      check("l240 hit_y",       last_hy, 240);
      check("l240 pulse lines", low_rises - r0, 2);
      check("l240 sense before vblank", int'(sense_n), 0);
      vblank = 1'b1;
      hblank = 1'b0;
      @(negedge clk_sys);
      check("l240 sense on vblank rise cycle", int'(sense_n), 0);
      @(negedge clk_sys);
      check("l240 sense after vblank rise", int'(sense_n), 1);
      @(posedge clk_sys);
      #1;
      h0 = hit_total;
      run_frame(8, 242, 4, 240, 4'hF, 0);
      check("next frame hits", hit_total - h0, 1);

      // Trigger path: low three clocks after the raw input.
      gun_en = 1'b1;
      trigger_raw = 1'b0;
      repeat (4) tick();
      trigger_raw = 1'b1;
      tick();
      tick();
      check("trigger_n after 2 clk", int'(trigger_n), 1);
      tick();
      check("trigger_n after 3 clk", int'(trigger_n), 0);
      trigger_raw = 1'b0;
      repeat (3) tick();
      check("trigger_n released", int'(trigger_n), 1);
      gun_en = 1'b0;
      trigger_raw = 1'b1;
      repeat (4) tick();
      check("trigger_n gun_en=0", int'(trigger_n), 1);
      trigger_raw = 1'b0;

      // Reset in the middle of a pulse drops sense_n high without a clock edge.
      gun_en = 1'b1; gun_x = 9'd0; gun_y = 9'd0;
      tick();
      vblank = 1'b1; hblank = 1'b1; mclk0 = 1'b0; uv_in = 8'h00;
      tick();
      vblank = 1'b0; hblank = 1'b0; mclk0 = 1'b1; uv_in = 8'h0F;
      @(negedge clk_sys);
      check("manual hit strobe", int'(hit), 1);
      @(posedge clk_sys);
      #1;
      mclk0 = 1'b0; uv_in = 8'h00;
      #3;
      check("manual sense low", int'(sense_n), 0);
      reset = 1'b1;
      #1;
      check("async reset sense_n", int'(sense_n), 1);
      check("async reset beam_x",  int'(beam_x),  0);
      tick();
      reset = 1'b0;
      tick();
      check("post reset sense_n", int'(sense_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
